// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Also provides the full-adder cell used by the trial-subtract ripple.
package div_pkg;

   localparam int unsigned DividendWDef = 8;
   localparam int unsigned DivisorWDef  = 4;
   localparam int unsigned CntWDef      = $clog2(DividendWDef);

   localparam logic [DividendWDef-1:0] DivZeroQuot = 8'hFF;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StDone = 2'b10
   } state_e;

   function automatic logic fa_sum(input logic a, input logic b, input logic ci);
      return a ^ b ^ ci;
   endfunction

   function automatic logic fa_carry(input logic a, input logic b, input logic ci);
      return (a & b) | (ci & (a ^ b));
   endfunction

endpackage

// File: rtl/div_step.sv
// Combinational trial-subtract cell: R - divisor as a ripple of full adders
// (divisor inverted, carry-in 1); carry-out high means the difference is non-negative.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned DIVISOR_W = DivisorWDef
) (
   input  logic [DIVISOR_W:0]   r_shift_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W-1:0] r_next_o,
   output logic                 q_bit_o
);

   logic [DIVISOR_W:0]   carry;
   logic [DIVISOR_W-1:0] diff;

   always_comb begin
      carry = '0;
      diff  = '0;
      carry[0] = 1'b1;
      for (int i = 0; i < int'(DIVISOR_W); i++) begin
         diff[i]    = fa_sum(r_shift_i[i], ~divisor_i[i], carry[i]);
         carry[i+1] = fa_carry(r_shift_i[i], ~divisor_i[i], carry[i]);
      end
   end

   // Top stage subtracts the zero-extension bit (inverted to 1); only its carry matters,
   // since an accepted difference is always below the divisor and fits the low bits.
   assign q_bit_o  = fa_carry(r_shift_i[DIVISOR_W], 1'b1, carry[DIVISOR_W]);
   assign r_next_o = q_bit_o ? diff : r_shift_i[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock with a start/busy/done handshake.
// Divide-by-zero short-circuits straight to DONE with an all-ones quotient.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DividendWDef,
   parameter int unsigned DIVISOR_W  = DivisorWDef
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [DIVIDEND_W-1:0] dividend_i,
   input  logic [DIVISOR_W-1:0]  divisor_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DIVIDEND_W-1:0] quotient_o,
   output logic [DIVISOR_W-1:0]  remainder_o,
   output logic                  div_by_zero_o
);

   localparam int unsigned CntW = $clog2(DIVIDEND_W);

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] q_work_q, q_work_d;
   // Only the low bits of R are stored: after every step R < divisor, so R[top] is 0.
   logic [DIVISOR_W-1:0]  r_q, r_d;
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  dbz_q, dbz_d;

   logic [DIVISOR_W:0]    r_shift;
   logic [DIVISOR_W-1:0]  r_next;
   logic                  q_bit;
   logic [DIVIDEND_W-1:0] q_shift;

   assign r_shift = {r_q, q_work_q[DIVIDEND_W-1]};
   assign q_shift = {q_work_q[DIVIDEND_W-2:0], q_bit};

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .r_shift_i (r_shift),
      .divisor_i (divisor_q),
      .r_next_o  (r_next),
      .q_bit_o   (q_bit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      q_work_d    = q_work_q;
      r_d         = r_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (divisor_i != '0) begin
                  state_d   = StCalc;
                  q_work_d  = dividend_i;
                  r_d       = '0;
                  cnt_d     = CntW'(DIVIDEND_W - 1);
                  divisor_d = divisor_i;
               end else begin
                  state_d     = StDone;
                  quotient_d  = DivZeroQuot;
                  remainder_d = '0;
                  dbz_d       = 1'b1;
               end
            end
         end
         StCalc: begin
            q_work_d = q_shift;
            r_d      = r_next;
            cnt_d    = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               state_d     = StDone;
               quotient_d  = q_shift;
               remainder_d = r_next;
               dbz_d       = 1'b0;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         q_work_q    <= '0;
         r_q         <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         q_work_q    <= q_work_d;
         r_q         <= r_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy_o        = (state_q == StCalc);
   assign done_o        = (state_q == StDone);
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: driver pushes arithmetic expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_restoring_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy, done, dbz;
   logic [7:0] quotient;
   logic [3:0] remainder;

   typedef struct {
      int q;
      int r;
      int dbz;
      int busy;
      int acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   logic prev_done = 1'b0;

   seq_restoring_divider dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .busy_o        (busy),
      .done_o        (done),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .div_by_zero_o (dbz)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic exp_t model(input int a, input int b, input int acc);
      exp_t e;
      e.acc_cyc = acc;
      if (b == 0) begin
         e.q = 255; e.r = 0; e.dbz = 1; e.busy = 0;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 0; e.busy = 8;
      end
      return e;
   endfunction

   // Monitor
   initial forever begin
      exp_t e;
      int   lat;
      @(negedge clk);
      if (rst) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            check("done_width", int'(prev_done), 0);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: got done with empty scoreboard (t=%0t)", $time);
            end else begin
               e   = sb.pop_front();
               lat = cyc - e.acc_cyc;
               check("quotient", int'(quotient), e.q);
               check("remainder", int'(remainder), e.r);
               check("div_by_zero", int'(dbz), e.dbz);
               check("busy_cycles", busy_cnt, e.busy);
               if (e.dbz == 0) check("latency", lat, 8);
               else check("dbz_latency_le1", int'(lat <= 1), 1);
            end
            busy_cnt = 0;
         end
         prev_done = done;
      end
   end

   task automatic issue(input int a, input int b, input bit hold);
      int n = 0;
      @(negedge clk);
      while ((busy || done) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
      end
      dividend = 8'(a);
      divisor  = 4'(b);
      start    = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(a, b, cyc));
      if (!hold) start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_quotient"}, int'(quotient), 0);
      check({tag, "_remainder"}, int'(remainder), 0);
      check({tag, "_dbz"}, int'(dbz), 0);
   endtask

   initial begin
      int n;
      int a_tab[6] = '{143, 200, 255, 7, 99, 10};
      int b_tab[6] = '{11, 15, 1, 9, 0, 3};

      @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) issue(a_tab[i], b_tab[i], 1'b0);

      // Start pulsed mid-calculation must be ignored.
      issue(143, 11, 1'b0);
      repeat (3) @(negedge clk);
      dividend = 8'd200;
      divisor  = 4'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Reset mid-division after a divide-by-zero left non-zero outputs.
      issue(99, 0, 1'b0);
      issue(200, 15, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero("abort");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue(143, 11, 1'b0);

      for (int i = 0; i < 200; i++) issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b1);

      for (int b = 1; b < 16; b++)
         for (int a = 0; a < 256; a++) issue(a, b, 1'b1);
      start = 1'b0;

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
